spy_bridge: RTL and testbench
=============================

Name: spy_bridge

Overview:
- Parametrised successor to the serial spy port: turns a byte stream of nibble-coded debug commands into register reads and writes on the spy bus (eadr/dbread/dbwrite/spy_out/spy_in).
- Generalised in data width, address width and read latency. Talks to any byte-level UART through valid/ready handshakes on both directions.
- Sits between the debug UART and the processor's spy register bank.

Parameters:
- DATA_W, 16, spy data width; a multiple of 4, from 8 to 32. NIB = DATA_W/4.
- ADDR_W, 5, spy address width, from 4 to 8.
- READ_LAT, 1, cycles from dbread rising to spy_in valid; from 1 to 7.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- rx_data  in  8  received command byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  bridge accepts byte; transfer when rx_valid&rx_ready
- tx_data  out  8  response byte
- tx_valid  out  1  tx_data valid; held with tx_data stable until tx_ready
- tx_ready  in  1  UART accepts byte
- eadr  out  ADDR_W  spy register address
- dbread  out  1  spy read strobe
- dbwrite  out  1  spy write strobe
- spy_out  out  DATA_W  spy write data
- spy_in  in  DATA_W  spy read data

Behaviour:
- Reset (async, reset_n=0): state=IDLE; data, addr_hi, eadr, spy_out = 0; dbread, dbwrite, tx_valid = 0; rx_ready=0; nibble counter = 0. Reset mid-operation aborts immediately: no partial strobe, no further tx bytes.
- Command byte = {op[3:0], arg[3:0]}, decoded in IDLE on an accepted byte:
  - op 0x3: data <= {data[DATA_W-5:0], arg} (shift in nibble, MS first).
  - op 0x7: addr_hi <= arg. addr = {addr_hi, arg} truncated to ADDR_W.
  - op 0x8/0x9: read. eadr <= addr; go to READ.
  - op 0xA/0xB: write. eadr <= addr; spy_out <= data; go to WRITE.
  - Any other op: ignored, stay IDLE.
- rx_ready=1 only in IDLE. Bytes arriving while busy are back-pressured, never dropped.
- States:
  - IDLE
  - WRITE: dbwrite=1 exactly one cycle, eadr/spy_out already stable; then IDLE. Accept-to-dbwrite latency is 1 cycle.
  - READ: dbread=1 for READ_LAT cycles. On the last cycle, capture resp <= spy_in, then go to TX with nibble counter = NIB-1.
  - TX: tx_valid=1, tx_data = {tag, resp nibble[counter]}, MS nibble first.
    - tag: 0x3 for the first byte, 0x6 for the last byte, 0x4 for the others.
    - If NIB==1 is impossible (DATA_W>=8), so first and last never coincide.
    - On tx_valid&tx_ready: if counter==0, go to IDLE; else decrement the counter and present the next byte the following cycle. tx_valid may stay high back-to-back.
- Read total: 1 accept cycle + READ_LAT cycles, then NIB bytes.
- dbread and dbwrite never assert together. dbread is registered and glitch-free.
- Simultaneous rx_valid and an in-flight transaction: no effect until return to IDLE. The byte stays pending.
- data is not cleared by read or write; repeated 0xA commands rewrite the same value.

Optional Feature:
- SPY_AUTOINC_EN defined: after each completed read (last tx byte accepted) or write (dbwrite cycle), {addr_hi, addr_lo} increments by 1, wrapping modulo 2^ADDR_W. A following op 0x8/0xA with arg 0xF uses the incremented address instead of arg. Other args behave normally.
- Not defined: no address state beyond addr_hi; arg 0xF addresses register {addr_hi, 0xF} as usual.

Test Plan:
- Write, defaults: bytes 0x31,0x32,0x33,0x34,0xA5 -> one-cycle dbwrite with eadr=5, spy_out=0x1234; no tx bytes.
- Read: spy_in=0xBEEF, byte 0x8C -> dbread high 1 cycle with eadr=0xC; tx bytes 0x3B,0x4E,0x4E,0x6F in order.
- Tx backpressure: tx_ready held low 10 cycles per byte during the read above -> tx_data stable while tx_valid; rx_ready=0 throughout; a byte 0x31 sent meanwhile is accepted only after the last tx byte.
- DATA_W=32, ADDR_W=8, READ_LAT=3: bytes 0x71,0x82 with spy_in=0xCAFE0123 -> eadr=0x12; dbread 3 cycles; tx bytes 0x3C,0x4A,0x4F,0x4E,0x40,0x41,0x42,0x63.
- Unknown op 0xE5, then reset_n pulsed low during the 2nd tx byte -> the unknown op produces no strobe or tx; after reset all outputs are 0, and no further tx_valid until a new read.
- SPY_AUTOINC_EN: write at 0x1F (0x71,0xAF), then 0xAF -> second dbwrite at eadr=0x00 (wrap with ADDR_W=5).

Source files
------------

// File: rtl/spy_bridge.sv
// spy_bridge: byte-stream debug command decoder driving the spy register bus.
//
// Each command byte is {op, arg}. Op 0x3 shifts a nibble into the data
// register, 0x7 sets the high address nibble, 0x8/0x9 reads and 0xA/0xB
// writes the spy register at {addr_hi, arg}. A read result is returned as
// NIB bytes {tag, nibble}, most significant nibble first, tagged 0x3 (first),
// 0x4 (middle) and 0x6 (last).
//
// Parameters:
//   DATA_W   spy data width, multiple of 4, 8..32
//   ADDR_W   spy address width, 4..8
//   READ_LAT cycles from dbread rising to spy_in valid, 1..7
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   rx_data/valid/ready command byte stream in (valid/ready handshake)
//   tx_data/valid/ready response byte stream out (valid/ready handshake)
//   eadr                spy register address
//   dbread, dbwrite     spy read / write strobes
//   spy_out, spy_in     spy write data / read data
//
// Build option:
//   SPY_AUTOINC_EN      address auto-increment after each completed access;
//                       arg 0xF on a read/write then selects the incremented
//                       address.
module spy_bridge #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] eadr,
  output logic              dbread,
  output logic              dbwrite,
  output logic [DATA_W-1:0] spy_out,
  input  logic [DATA_W-1:0] spy_in
);

  localparam int NIB   = DATA_W / 4;
  localparam int CNT_W = $clog2(NIB);
  localparam int LAT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_TX
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [3:0]          addr_hi_q, addr_hi_d;
  logic [ADDR_W-1:0]   eadr_q, eadr_d;
  logic [DATA_W-1:0]   spy_out_q, spy_out_d;
  logic [DATA_W-1:0]   resp_q, resp_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic                dbread_q, dbread_d;
  logic                rx_ready_q, rx_ready_d;
`ifdef SPY_AUTOINC_EN
  logic [ADDR_W-1:0]   ainc_q, ainc_d;
  logic                ainc_vld_q, ainc_vld_d;
  logic [ADDR_W-1:0]   ainc_nxt;
  logic                acc_done;
`endif

  logic [3:0]          op, arg;
  logic                rx_fire, tx_fire, lat_last, is_rd, is_wr;
  logic [ADDR_W-1:0]   addr_cmd;

  assign op       = rx_data[7:4];
  assign arg      = rx_data[3:0];
  assign rx_fire  = rx_valid && rx_ready_q;
  assign tx_fire  = (state_q == S_TX) && tx_ready;
  assign lat_last = (lat_q == LAT_W'(READ_LAT - 1));
  assign is_rd    = (op == 4'h8) || (op == 4'h9);
  assign is_wr    = (op == 4'hA) || (op == 4'hB);

`ifdef SPY_AUTOINC_EN
  // The incremented address is only honoured once an access has completed
  // since the last explicit high-nibble load; otherwise arg 0xF is literal.
  assign addr_cmd = (ainc_vld_q && (arg == 4'hF)) ? ainc_q
                                                  : ADDR_W'({addr_hi_q, arg});
  assign ainc_nxt = eadr_q + ADDR_W'(1);
  assign acc_done = (state_q == S_WRITE) || (tx_fire && (cnt_q == '0));
`else
  assign addr_cmd = ADDR_W'({addr_hi_q, arg});
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      addr_hi_q  <= '0;
      eadr_q     <= '0;
      spy_out_q  <= '0;
      resp_q     <= '0;
      cnt_q      <= '0;
      lat_q      <= '0;
      dbread_q   <= 1'b0;
      rx_ready_q <= 1'b0;
`ifdef SPY_AUTOINC_EN
      ainc_q     <= '0;
      ainc_vld_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      addr_hi_q  <= addr_hi_d;
      eadr_q     <= eadr_d;
      spy_out_q  <= spy_out_d;
      resp_q     <= resp_d;
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
      dbread_q   <= dbread_d;
      rx_ready_q <= rx_ready_d;
`ifdef SPY_AUTOINC_EN
      ainc_q     <= ainc_d;
      ainc_vld_q <= ainc_vld_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          if (is_rd)      state_d = S_READ;
          else if (is_wr) state_d = S_WRITE;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_READ:  if (lat_last) state_d = S_TX;
      S_TX:    if (tx_fire && (cnt_q == '0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    data_d    = data_q;
    addr_hi_d = addr_hi_q;
    eadr_d    = eadr_q;
    spy_out_d = spy_out_q;
    resp_d    = resp_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
`ifdef SPY_AUTOINC_EN
    ainc_d     = ainc_q;
    ainc_vld_d = ainc_vld_q;
`endif

    if ((state_q == S_IDLE) && rx_fire) begin
      if (op == 4'h3) data_d = {data_q[DATA_W-5:0], arg};
      if (op == 4'h7) begin
        addr_hi_d = arg;
`ifdef SPY_AUTOINC_EN
        ainc_vld_d = 1'b0;
`endif
      end
      if (is_rd || is_wr) eadr_d = addr_cmd;
      if (is_wr) spy_out_d = data_q;
      if (is_rd) lat_d = '0;
    end

    if (state_q == S_READ) begin
      lat_d = lat_q + LAT_W'(1);
      if (lat_last) begin
        resp_d = spy_in;
        cnt_d  = CNT_W'(NIB - 1);
      end
    end

    if (tx_fire && (cnt_q != '0)) cnt_d = cnt_q - CNT_W'(1);

`ifdef SPY_AUTOINC_EN
    if (acc_done) begin
      ainc_d     = ainc_nxt;
      ainc_vld_d = 1'b1;
      addr_hi_d  = 4'(8'(ainc_nxt) >> 4);
    end
`endif

    // Registered from the next state so the strobe and handshake are glitch-free.
    dbread_d   = (state_d == S_READ);
    rx_ready_d = (state_d == S_IDLE);
  end

  // Outputs
  always_comb begin
    rx_ready = rx_ready_q;
    dbread   = dbread_q;
    dbwrite  = (state_q == S_WRITE);
    tx_valid = (state_q == S_TX);
    eadr     = eadr_q;
    spy_out  = spy_out_q;
    tx_data  = '0;
    if (state_q == S_TX) begin
      tx_data[3:0] = resp_q[{cnt_q, 2'b00} +: 4];
      if (cnt_q == CNT_W'(NIB - 1)) tx_data[7:4] = 4'h3;
      else if (cnt_q == '0)         tx_data[7:4] = 4'h6;
      else                          tx_data[7:4] = 4'h4;
    end
  end

endmodule

// File: tb/tb_spy_bridge.sv
module tb_spy_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // u0: default parameters
  logic [7:0]  rx_data0, tx_data0;
  logic        rx_valid0, rx_ready0, tx_valid0, tx_ready0;
  logic [4:0]  eadr0;
  logic        dbread0, dbwrite0;
  logic [15:0] spy_out0, spy_in0;

  // u1: wide configuration
  logic [7:0]  rx_data1, tx_data1;
  logic        rx_valid1, rx_ready1, tx_valid1, tx_ready1;
  logic [7:0]  eadr1;
  logic        dbread1, dbwrite1;
  logic [31:0] spy_out1, spy_in1;

  spy_bridge #(.DATA_W(16), .ADDR_W(5), .READ_LAT(1)) u0 (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .eadr(eadr0), .dbread(dbread0), .dbwrite(dbwrite0),
    .spy_out(spy_out0), .spy_in(spy_in0)
  );

  spy_bridge #(.DATA_W(32), .ADDR_W(8), .READ_LAT(3)) u1 (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .eadr(eadr1), .dbread(dbread1), .dbwrite(dbwrite1),
    .spy_out(spy_out1), .spy_in(spy_in1)
  );

  // Scoreboard queues: tx bytes, writes {adr8, dat32}, reads {adr8, len8}
  logic [7:0]  exp_tx0[$], exp_tx1[$];
  logic [39:0] exp_wr0[$];
  logic [15:0] exp_rd0[$], exp_rd1[$];

  int n_cmp = 0, n_bad = 0, n_tmo = 0;
  bit done = 1'b0;

  // ---------------------------------------------------------------- monitor
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic unexp(input string nm, input logic [63:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected event value %0h expected none at %0t", nm, act, $time);
  endtask

  int          rd_len0 = 0, rd_len1 = 0;
  logic [7:0]  rd_adr0, rd_adr1;
  bit          hold0 = 1'b0;
  logic [7:0]  prev0;
  logic [39:0] ew;
  logic [15:0] er;
  logic [7:0]  et;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst0_out", {rx_ready0, tx_valid0, dbread0, dbwrite0, tx_data0, eadr0, spy_out0}, '0);
      chk("rst1_out", {rx_ready1, tx_valid1, dbread1, dbwrite1, tx_data1, eadr1, spy_out1}, '0);
      rd_len0 = 0;
      rd_len1 = 0;
      hold0   = 1'b0;
    end else begin
      // ---- u0
      if (dbread0 || dbwrite0) chk("excl0", 64'(dbread0 & dbwrite0), 64'(0));
      if (dbread0 || dbwrite0 || tx_valid0) chk("rxrdy_busy0", 64'(rx_ready0), 64'(0));
      if (dbwrite0) begin
        if (exp_wr0.size() == 0) unexp("wr0", {eadr0, spy_out0});
        else begin
          ew = exp_wr0.pop_front();
          chk("wr0", {eadr0, spy_out0}, {ew[36:32], ew[15:0]});
        end
      end
      if (dbread0) begin
        rd_len0++;
        rd_adr0 = {3'b000, eadr0};
      end else if (rd_len0 != 0) begin
        if (exp_rd0.size() == 0) unexp("rd0", {rd_adr0, 8'(rd_len0)});
        else begin
          er = exp_rd0.pop_front();
          chk("rd0", {rd_adr0, 8'(rd_len0)}, er);
        end
        rd_len0 = 0;
      end
      if (hold0 && tx_valid0) chk("txhold0", tx_data0, prev0);
      if (tx_valid0 && tx_ready0) begin
        if (exp_tx0.size() == 0) unexp("tx0", tx_data0);
        else begin
          et = exp_tx0.pop_front();
          chk("tx0", tx_data0, et);
        end
      end
      hold0 = tx_valid0 && !tx_ready0;
      prev0 = tx_data0;

      // ---- u1
      if (dbwrite1) unexp("wr1", {eadr1, spy_out1});
      if (dbread1 || tx_valid1) chk("rxrdy_busy1", 64'(rx_ready1), 64'(0));
      if (dbread1) begin
        rd_len1++;
        rd_adr1 = eadr1;
      end else if (rd_len1 != 0) begin
        if (exp_rd1.size() == 0) unexp("rd1", {rd_adr1, 8'(rd_len1)});
        else begin
          er = exp_rd1.pop_front();
          chk("rd1", {rd_adr1, 8'(rd_len1)}, er);
        end
        rd_len1 = 0;
      end
      if (tx_valid1 && tx_ready1) begin
        if (exp_tx1.size() == 0) unexp("tx1", tx_data1);
        else begin
          et = exp_tx1.pop_front();
          chk("tx1", tx_data1, et);
        end
      end
    end

    if (done) begin
      chk("left_tx0", exp_tx0.size(), 0);
      chk("left_wr0", exp_wr0.size(), 0);
      chk("left_rd0", exp_rd0.size(), 0);
      chk("left_tx1", exp_tx1.size(), 0);
      chk("left_rd1", exp_rd1.size(), 0);
      chk("timeouts", n_tmo, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic send(input int which, input logic [7:0] b);
    int t;
    t = 0;
    if (which == 0) begin rx_data0 = b; rx_valid0 = 1'b1; end
    else            begin rx_data1 = b; rx_valid1 = 1'b1; end
    forever begin
      @(negedge clk);
      if ((which == 0) ? rx_ready0 : rx_ready1) break;
      t++;
      if (t > 300) begin
        n_tmo++;
        $display("FAIL send_timeout: byte %0h never accepted by dut %0d", b, which);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (which == 0) rx_valid0 = 1'b0;
    else            rx_valid1 = 1'b0;
  endtask

  task automatic expect_read0_beef();
    exp_rd0.push_back({8'h0C, 8'd1});
    exp_tx0.push_back(8'h3B);
    exp_tx0.push_back(8'h4E);
    exp_tx0.push_back(8'h4E);
    exp_tx0.push_back(8'h6F);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] wbytes[5] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'hA5};
  logic [7:0] tx1_bytes[8] = '{8'h3C, 8'h4A, 8'h4F, 8'h4E, 8'h40, 8'h41, 8'h42, 8'h63};

  initial begin
    int t;
    rx_data0 = '0; rx_valid0 = 1'b0; tx_ready0 = 1'b1; spy_in0 = 16'hBEEF;
    rx_data1 = '0; rx_valid1 = 1'b0; tx_ready1 = 1'b1; spy_in1 = 32'hCAFE0123;
    reset_n = 1'b0;
    cycles(3);
    reset_n = 1'b1;
    cycles(2);

    // Write with default address/data path
    exp_wr0.push_back({8'h05, 32'h0000_1234});
    foreach (wbytes[i]) send(0, wbytes[i]);
    cycles(5);

    // Plain read
    expect_read0_beef();
    send(0, 8'h8C);
    cycles(12);

    // Read under tx backpressure, with a data nibble queued behind it
    tx_ready0 = 1'b0;
    expect_read0_beef();
    send(0, 8'h8C);
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          cycles(10);
          tx_ready0 = 1'b1;
          cycles(1);
          tx_ready0 = 1'b0;
        end
      end
      send(0, 8'h31);
    join
    tx_ready0 = 1'b1;
    exp_wr0.push_back({8'h05, 32'h0000_2341});
    send(0, 8'hA5);
    cycles(5);

    // Unknown op: no strobe, no response
    send(0, 8'hE5);
    cycles(10);

    // Wide configuration read
    exp_rd1.push_back({8'h12, 8'd3});
    foreach (tx1_bytes[i]) exp_tx1.push_back(tx1_bytes[i]);
    send(1, 8'h71);
    send(1, 8'h82);
    cycles(25);

    // Reset while the second response byte is pending
    tx_ready0 = 1'b0;
    exp_rd0.push_back({8'h0C, 8'd1});
    exp_tx0.push_back(8'h3B);
    send(0, 8'h8C);
    t = 0;
    while (!tx_valid0 && t < 50) begin @(negedge clk); t++; end
    if (!tx_valid0) begin
      n_tmo++;
      $display("FAIL tx_valid_timeout: no response byte from dut 0");
    end
    cycles(1);
    tx_ready0 = 1'b1;
    cycles(1);
    tx_ready0 = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b0;
    cycles(3);
    reset_n = 1'b1;
    tx_ready0 = 1'b1;
    cycles(20);

    // Fresh read after reset
    expect_read0_beef();
    send(0, 8'h8C);
    cycles(10);

    // Address 0x1F twice via arg 0xF
    send(0, 8'h35);
    exp_wr0.push_back({8'h1F, 32'h0000_0005});
    send(0, 8'h71);
    send(0, 8'hAF);
    cycles(4);
`ifdef SPY_AUTOINC_EN
    exp_wr0.push_back({8'h00, 32'h0000_0005});
`else
    exp_wr0.push_back({8'h1F, 32'h0000_0005});
`endif
    send(0, 8'hAF);
    cycles(6);

    done = 1'b1;
    cycles(10);
    $display("FAIL monitor_end: summary not reached");
    $fatal(1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
